// File: rtl/seqdet_prog.sv
// seqdet_prog: programmable serial sequence detector.
//
// Watches a 1-bit serial stream qualified by valid. It pulses z when the most
// recent L accepted bits equal the loaded pattern. The first bit received is
// compared against pattern[L-1], and the last bit against pattern[0].
// L is the loaded length, clamped to MAX_LEN. A length of 0 never matches.
// Detection can be overlapping or non-overlapping. A saturating count of
// matches is kept.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset, clears all state
//   x, valid     serial bit and its qualifier
//   load         latch pattern/len/overlap and clear history (beats valid)
//   pattern      MAX_LEN-bit pattern, pattern[len-1] is the first bit
//   len          pattern length (LEN_W bits)
//   overlap      1 = overlapping detection, 0 = non-overlapping
//   clr_count    synchronous clear of match_count (beats a same-cycle match)
//   z            registered one-cycle match pulse
//   fill         number of valid history bits, saturating at MAX_LEN
//   match_count  saturating match counter
module seqdet_prog #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               x,
  input  logic               valid,
  input  logic               load,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic               overlap,
  input  logic               clr_count,
  output logic               z,
  output logic [LEN_W-1:0]   fill,
  output logic [CNT_W-1:0]   match_count
);

  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] cfg_pat_q;
  logic [LEN_W-1:0]   cfg_len_q;
  logic               cfg_ovl_q;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               z_q, z_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [LEN_W-1:0]   eff_len;
  logic [MAX_LEN-1:0] nh, mask;
  logic [LEN_W-1:0]   nf;
  logic               accept, match;

  always_comb begin
    eff_len = (cfg_len_q > MAX_L) ? MAX_L : cfg_len_q;
    nh      = {hist_q[MAX_LEN-2:0], x};
    nf      = (fill_q >= MAX_L) ? MAX_L : fill_q + 1'b1;
    // Keep only the low eff_len bits. History bits older than the pattern
    // are ignored.
    mask    = '0;
    for (int i = 0; i < MAX_LEN; i++)
      mask[i] = (LEN_W'(i) < eff_len);
    accept  = valid && !load;
    match   = accept && (eff_len != '0) && (nf >= eff_len) &&
              (((nh ^ cfg_pat_q) & mask) == '0);

    hist_d = hist_q;
    fill_d = fill_q;
    z_d    = 1'b0;
    if (load) begin
      hist_d = '0;
      fill_d = '0;
    end else if (accept) begin
      hist_d = nh;
      // Non-overlap: the history is kept, but fill=0 forces L fresh bits.
      fill_d = (match && !cfg_ovl_q) ? '0 : nf;
      z_d    = match;
    end

    cnt_d = cnt_q;
    if (clr_count)
      cnt_d = '0;
    else if (match && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg_pat_q <= '0;
      cfg_len_q <= '0;
      cfg_ovl_q <= 1'b0;
      hist_q    <= '0;
      fill_q    <= '0;
      z_q       <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if (load) begin
        cfg_pat_q <= pattern;
        cfg_len_q <= len;
        cfg_ovl_q <= overlap;
      end
      hist_q <= hist_d;
      fill_q <= fill_d;
      z_q    <= z_d;
      cnt_q  <= cnt_d;
    end
  end

  assign z           = z_q;
  assign fill        = fill_q;
  assign match_count = cnt_q;

endmodule
